// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the req/ready fetch port and the IF/ID register.
// Honours decode stalls, delay-slot redirects, flushes and variable-latency memory responses.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ready,
  input  logic [31:0] inst_rdata,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pc_redirect_valid,
  input  logic [31:0] pc_redirect_target,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pc_plus4D,
  output logic        validD,
  output logic        adelD
);

  typedef enum logic [0:0] {S_REQ = 1'b0, S_HOLD = 1'b1} fsm_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        adel;
  } ifid_t;

  fsm_e        r_fsm, w_fsm_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_buf, w_buf_nxt;
  logic        r_redir_pend, w_redir_pend_nxt;
  logic [31:0] r_redir_pc, w_redir_pc_nxt;
  logic        r_drop, w_drop_nxt;
  ifid_t       r_ifid, w_ifid_nxt;

  logic        w_mis;
  logic        w_got;
  logic [31:0] w_rdata;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_seq;

  assign inst_req  = (r_fsm == S_REQ) && !w_mis && !rst;
  assign inst_addr = r_pc;
  assign instrD    = r_ifid.instr;
  assign pcD       = r_ifid.pc;
  assign pc_plus4D = r_ifid.pc_plus4;
  assign validD    = r_ifid.valid;
  assign adelD     = r_ifid.adel;

  // A misaligned PC never reaches memory; it completes at once with a zero word and adel set.
  always_comb begin
    w_mis      = (r_pc[1:0] != 2'b00);
    w_got      = (r_fsm == S_REQ) && (inst_ready || w_mis);
    w_rdata    = w_mis ? 32'h0000_0000 : inst_rdata;
    w_pc_plus4 = r_pc + 32'd4;
    if (pc_redirect_valid && !stallD) begin
      w_next_seq = pc_redirect_target;
    end else if (r_redir_pend) begin
      w_next_seq = r_redir_pc;
    end else begin
      w_next_seq = w_pc_plus4;
    end

    w_fsm_nxt        = r_fsm;
    w_pc_nxt         = r_pc;
    w_buf_nxt        = r_buf;
    w_redir_pend_nxt = r_redir_pend;
    w_redir_pc_nxt   = r_redir_pc;
    w_drop_nxt       = r_drop;
    w_ifid_nxt       = r_ifid;

    if (flushD) begin
      w_ifid_nxt = '0;
      // An accepted request cannot be withdrawn: keep the address stable and discard its response.
      if ((r_fsm == S_REQ) && !w_mis && !inst_ready) begin
        w_drop_nxt       = 1'b1;
        w_redir_pend_nxt = 1'b1;
        w_redir_pc_nxt   = pc_redirect_target;
      end else begin
        w_pc_nxt         = pc_redirect_target;
        w_fsm_nxt        = S_REQ;
        w_redir_pend_nxt = 1'b0;
        w_drop_nxt       = 1'b0;
      end
    end else if (r_drop) begin
      if (inst_ready) begin
        w_pc_nxt         = r_redir_pc;
        w_redir_pend_nxt = 1'b0;
        w_drop_nxt       = 1'b0;
      end else begin
        w_drop_nxt       = 1'b1;
      end
      if (!stallD) begin
        w_ifid_nxt = '0;
      end else begin
        w_ifid_nxt = r_ifid;
      end
    end else begin
      case (r_fsm)
        S_REQ: begin
          if (w_got && !stallD) begin
            w_ifid_nxt       = '{instr: w_rdata, pc: r_pc, pc_plus4: w_pc_plus4, valid: 1'b1, adel: w_mis};
            w_pc_nxt         = w_next_seq;
            w_redir_pend_nxt = 1'b0;
          end else if (w_got) begin
            w_buf_nxt = w_rdata;
            w_fsm_nxt = S_HOLD;
          end else if (!stallD) begin
            w_ifid_nxt = '0;
            // The word still in flight is the delay slot; remember where to go after it.
            if (pc_redirect_valid) begin
              w_redir_pend_nxt = 1'b1;
              w_redir_pc_nxt   = pc_redirect_target;
            end else begin
              w_redir_pend_nxt = r_redir_pend;
            end
          end else begin
            w_ifid_nxt = r_ifid;
          end
        end
        S_HOLD: begin
          if (!stallD) begin
            w_ifid_nxt       = '{instr: r_buf, pc: r_pc, pc_plus4: w_pc_plus4, valid: 1'b1, adel: w_mis};
            w_pc_nxt         = w_next_seq;
            w_fsm_nxt        = S_REQ;
            w_redir_pend_nxt = 1'b0;
          end else begin
            w_ifid_nxt = r_ifid;
          end
        end
        default: begin
          w_fsm_nxt = S_REQ;
        end
      endcase
    end
  end

  // State and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm        <= S_REQ;
      r_pc         <= RESET_PC;
      r_buf        <= 32'h0000_0000;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= 32'h0000_0000;
      r_drop       <= 1'b0;
      r_ifid       <= '0;
    end else begin
      r_fsm        <= w_fsm_nxt;
      r_pc         <= w_pc_nxt;
      r_buf        <= w_buf_nxt;
      r_redir_pend <= w_redir_pend_nxt;
      r_redir_pc   <= w_redir_pc_nxt;
      r_drop       <= w_drop_nxt;
      r_ifid       <= w_ifid_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized bench for if_stage; the random phase checks the instruction stream
// delivered to decode against a program-order model of branches, delay slots and flushes.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_rdata;
  logic        stallD;
  logic        flushD;
  logic        pc_redirect_valid;
  logic [31:0] pc_redirect_target;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pc_plus4D;
  logic        validD;
  logic        adelD;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] exp_pc, pend_tgt, cur, tgt, prev_addr, exp_word;
  logic        pend, was_pend, prev_req, prev_ready, rdy;
  int          idle;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_ready(inst_ready), .inst_rdata(inst_rdata), .stallD(stallD), .flushD(flushD),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect_target(pc_redirect_target),
    .instrD(instrD), .pcD(pcD), .pc_plus4D(pc_plus4D), .validD(validD), .adelD(adelD)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r);
    inst_ready = r;
    inst_rdata = r ? mem_word(inst_addr) : $urandom();
  endtask

  task automatic do_reset();
    rst = 1'b1; stallD = 1'b0; flushD = 1'b0;
    pc_redirect_valid = 1'b0; pc_redirect_target = 32'h0; inst_ready = 1'b0; inst_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset values
    rst = 1'b1; stallD = 1'b0; flushD = 1'b0;
    pc_redirect_valid = 1'b0; pc_redirect_target = 32'h0; inst_ready = 1'b0; inst_rdata = 32'h0;
    tick(); tick();
    chk("rst_req", {31'h0, inst_req}, 32'h0);
    chk("rst_instrD", instrD, 32'h0);
    chk("rst_pcD", pcD, 32'h0);
    chk("rst_pc4D", pc_plus4D, 32'h0);
    chk("rst_validD", {31'h0, validD}, 32'h0);
    chk("rst_adelD", {31'h0, adelD}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_req", {31'h0, inst_req}, 32'h1);
    chk("rel_addr", inst_addr, RESET_PC);

    // Zero-wait stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1); tick();
      chk("zw_pcD", pcD, RESET_PC + 32'(4 * i));
      chk("zw_validD", {31'h0, validD}, 32'h1);
      chk("zw_instrD", instrD, mem_word(RESET_PC + 32'(4 * i)));
      chk("zw_addr", inst_addr, RESET_PC + 32'(4 * (i + 1)));
    end

    // Stall while the word at +8 returns
    do_reset();
    drive(1'b1); tick(); drive(1'b1); tick();
    stallD = 1'b1; drive(1'b1); tick();
    chk("st_req", {31'h0, inst_req}, 32'h0);
    chk("st_pcD", pcD, RESET_PC + 32'd4);
    drive(1'b0); tick(); drive(1'b0); tick();
    chk("st3_pcD", pcD, RESET_PC + 32'd4);
    chk("st3_req", {31'h0, inst_req}, 32'h0);
    stallD = 1'b0; drive(1'b0); tick();
    chk("st_rel_pcD", pcD, RESET_PC + 32'd8);
    chk("st_rel_instrD", instrD, mem_word(RESET_PC + 32'd8));
    chk("st_rel_validD", {31'h0, validD}, 32'h1);
    chk("st_rel_addr", inst_addr, RESET_PC + 32'd12);
    chk("st_rel_req", {31'h0, inst_req}, 32'h1);
    drive(1'b1); tick();
    chk("st_next_pcD", pcD, RESET_PC + 32'd12);

    // Branch at +4 to 0xBFC00100 with a slow delay-slot fetch
    do_reset();
    drive(1'b1); tick(); drive(1'b1); tick();
    pc_redirect_valid = 1'b1; pc_redirect_target = 32'hBFC0_0100; drive(1'b0); tick();
    chk("br_bub1", {31'h0, validD}, 32'h0);
    pc_redirect_valid = 1'b0; pc_redirect_target = $urandom(); drive(1'b0); tick();
    chk("br_bub2", {31'h0, validD}, 32'h0);
    chk("br_wait_addr", inst_addr, RESET_PC + 32'd8);
    drive(1'b1); tick();
    chk("br_ds_pcD", pcD, RESET_PC + 32'd8);
    chk("br_ds_validD", {31'h0, validD}, 32'h1);
    chk("br_tgt_addr", inst_addr, 32'hBFC0_0100);

    // Flush during an outstanding request at +0x10
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1); tick();
    end
    chk("fl_pre_addr", inst_addr, RESET_PC + 32'h10);
    flushD = 1'b1; pc_redirect_target = 32'h8000_0180; drive(1'b0); tick();
    chk("fl_bub", {31'h0, validD}, 32'h0);
    chk("fl_hold_addr", inst_addr, RESET_PC + 32'h10);
    chk("fl_hold_req", {31'h0, inst_req}, 32'h1);
    flushD = 1'b0; pc_redirect_target = $urandom(); drive(1'b0); tick();
    chk("fl_hold_addr2", inst_addr, RESET_PC + 32'h10);
    drive(1'b1); tick();
    chk("fl_drop_valid", {31'h0, validD}, 32'h0);
    chk("fl_tgt_addr", inst_addr, 32'h8000_0180);
    drive(1'b1); tick();
    chk("fl_tgt_pcD", pcD, 32'h8000_0180);
    chk("fl_tgt_instrD", instrD, mem_word(32'h8000_0180));

    // Redirect to a misaligned target
    pc_redirect_valid = 1'b1; pc_redirect_target = 32'hBFC0_0102; drive(1'b1); tick();
    pc_redirect_valid = 1'b0;
    chk("mis_ds_pcD", pcD, 32'h8000_0184);
    chk("mis_req", {31'h0, inst_req}, 32'h0);
    drive(1'b0); tick();
    chk("mis_pcD", pcD, 32'hBFC0_0102);
    chk("mis_instrD", instrD, 32'h0);
    chk("mis_validD", {31'h0, validD}, 32'h1);
    chk("mis_adelD", {31'h0, adelD}, 32'h1);
    chk("mis_pc4D", pc_plus4D, 32'hBFC0_0106);

    // Randomized traffic against the program-order stream model
    do_reset();
    exp_pc = RESET_PC; pend = 1'b0; pend_tgt = 32'h0; idle = 0;
    prev_req = 1'b0; prev_ready = 1'b0; prev_addr = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      if (prev_req && !prev_ready) begin
        chk("rnd_req_held", {31'h0, inst_req}, 32'h1);
        chk("rnd_addr_stable", inst_addr, prev_addr);
      end
      stallD = ($urandom_range(3) == 0);
      flushD = ($urandom_range(49) == 0);
      pc_redirect_valid = 1'b0;
      pc_redirect_target = $urandom();
      rdy = inst_req && ($urandom_range(2) != 0);
      drive(rdy);
      if (validD && (!stallD || flushD)) begin
        cur = exp_pc;
        exp_word = (cur[1:0] != 2'b00) ? 32'h0 : mem_word(cur);
        chk("rnd_pcD", pcD, cur);
        chk("rnd_pc4D", pc_plus4D, cur + 32'd4);
        chk("rnd_instrD", instrD, exp_word);
        chk("rnd_adelD", {31'h0, adelD}, {31'h0, (cur[1:0] != 2'b00)});
        was_pend = pend;
        exp_pc = pend ? pend_tgt : cur + 32'd4;
        pend = 1'b0;
        idle = 0;
        if (!flushD && !was_pend && ($urandom_range(4) == 0)) begin
          tgt = $urandom();
          if ($urandom_range(9) != 0) tgt[1:0] = 2'b00;
          pc_redirect_valid = 1'b1;
          pc_redirect_target = tgt;
          pend = 1'b1;
          pend_tgt = tgt;
        end
      end else begin
        idle++;
      end
      if (flushD) begin
        tgt = $urandom() & 32'hFFFF_FFFC;
        pc_redirect_target = tgt;
        exp_pc = tgt;
        pend = 1'b0;
      end
      if (idle > 300) begin
        chk("rnd_liveness", 32'(idle), 32'h0);
        break;
      end
      prev_req = inst_req; prev_ready = inst_ready; prev_addr = inst_addr;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage (main decoder, ALU decoder, branch/jump resolution). It owns the PC, drives a req/ready instruction-memory port, and holds the IF/ID pipeline register that decode consumes. It honours decode stalls, decode-resolved redirects (branch/J/JAL/JR/JALR, with architectural delay slot) and flushes, and it tolerates variable memory latency.

## Interface
- RESET_PC, 32'hBFC00000, PC loaded on reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- inst_req  out  1  fetch request; held with a stable inst_addr until inst_ready.
- inst_addr  out  32  fetch address, always the current pc.
- inst_ready  in  1  response strobe; inst_rdata is valid in the same cycle.
- inst_rdata  in  32  fetched word.
- stallD  in  1  decode stall from hazard unit; IF/ID must hold.
- flushD  in  1  clear IF/ID and restart fetch at pc_redirect_target; has priority over stallD.
- pc_redirect_valid  in  1  decode resolved a taken control transfer; meaningful only when stallD=0 or flushD=1.
- pc_redirect_target  in  32  redirect/flush target.
- instrD  out  32  IF/ID instruction; 0 (nop) for a bubble.
- pcD  out  32  IF/ID PC.
- pc_plus4D  out  32  IF/ID PC+4 (link address source for JAL/JALR/BxxAL is pc_plus4D+4, computed in decode).
- validD  out  1  IF/ID holds a real instruction.
- adelD  out  1  IF/ID instruction came from a misaligned PC.

## Operation
- State: pc, fsm {REQ, HOLD}, buf (32), redir_pend, redir_pc (32), drop.
- Reset: pc=RESET_PC, fsm=REQ, redir_pend=drop=0; instrD=pcD=pc_plus4D=0, validD=adelD=0; inst_req=0 while rst=1.
- inst_req = (fsm==REQ) & pc[1:0]==0 & !rst. Misaligned pc: no request; behaves as an immediate response with rdata=0 and adel=1.
- "got" = REQ & (inst_ready | misaligned). next_seq = (pc_redirect_valid & !stallD) ? pc_redirect_target : redir_pend ? redir_pc : pc+4 (32-bit wrap).
- No flush, drop=0:
  - REQ, got, !stallD: IF/ID <= {pc, pc+4, rdata, valid=1, adel}; pc <= next_seq; redir_pend <= 0.
  - REQ, got, stallD: buf <= rdata; fsm <= HOLD; IF/ID holds.
  - REQ, !got, !stallD: IF/ID <= bubble (all 0); redirect, if present, captured: redir_pend<=1, redir_pc<=target.
  - REQ, !got, stallD: everything holds.
  - HOLD, !stallD: IF/ID <= {pc, pc+4, buf, 1, adel}; pc <= next_seq; fsm <= REQ; redir_pend <= 0.
  - HOLD, stallD: holds; inst_req=0.
- Delay slot: the word in flight when a redirect arrives is the delay slot and is always delivered; the target is fetched next.
- flushD=1 (target = pc_redirect_target): IF/ID <= bubble regardless of stallD.
  - REQ with outstanding request and inst_ready=0: drop<=1, redir_pend<=1, redir_pc<=target; inst_addr stays stable.
  - Otherwise (HOLD, got, or misaligned): buf discarded, pc<=target, fsm<=REQ, redir_pend<=0, drop<=0.
- drop=1 and inst_ready: response discarded, pc<=redir_pc, redir_pend<=0, drop<=0; IF/ID gets bubble if !stallD, else holds.
- A second flush while drop=1 overwrites redir_pc.

## Timing
- Zero-wait memory, no stalls: one instruction per cycle; the word returned with inst_ready in cycle N is on instrD in cycle N+1, and inst_addr advances in N+1.
- Each wait cycle inserts one bubble when decode is not stalled.
- HOLD to release: buffered word appears in IF/ID the cycle after stallD falls; the new request starts in that same cycle.
- Redirect latency: the target is on inst_addr one cycle after the delay slot is accepted.
- Flush: bubble in IF/ID the next cycle; target on inst_addr next cycle, or the cycle after the in-flight response returns.

## Test plan
- Reset: rst=1 for 2 cycles -> inst_req=0, all IF/ID outputs 0. Release -> inst_req=1, inst_addr=0xBFC00000.
- Zero-wait stream, ready=1 always -> pcD=0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles, validD=1, instrD equals memory contents.
- stallD=1 for 3 cycles while word at 0xBFC00008 returns -> inst_req=0, IF/ID frozen. One cycle after release, pcD=0xBFC00008; inst_addr=0xBFC0000C; no word lost or duplicated.
- Branch at 0xBFC00004 redirects to 0xBFC00100 while the delay-slot fetch (0xBFC00008) waits 2 cycles -> 2 bubbles (validD=0), then pcD=0xBFC00008, then inst_addr=0xBFC00100.
- flushD with target 0x80000180 during an outstanding request at 0xBFC00010 -> inst_addr held at 0xBFC00010 until ready, response discarded (validD stays 0), then inst_addr=0x80000180.
- Redirect target 0xBFC00102 -> no inst_req; next cycle pcD=0xBFC00102, instrD=0, validD=1, adelD=1.
